plane_pos_ctrl: RTL and testbench

PLANE_POS_CTRL -- requirements
Module: plane_pos_ctrl

---
 rtl/plane_pos_ctrl.sv | 80 ++++++++
 tb/tb_plane_pos_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/plane_pos_ctrl.sv
// plane_pos_ctrl: debounced button / joystick driven vertical plane position with per-frame steps
module plane_pos_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 448,
    parameter int Y_INIT     = 224
) (
    input  logic       clk_d,
    input  logic       reset,
    input  logic       move_up,
    input  logic       move_down,
    input  logic [3:0] vry,
    input  logic       high_s,
    input  logic       medium_s,
    input  logic       low_s,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic [9:0] plane_y,
    output logic [1:0] dir,
    output logic       frame_tick
);
    typedef enum logic [1:0] {HOLD = 2'b00, UP = 2'b01, DOWN = 2'b10} dir_t;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_END = CW'(DEB_CYCLES - 1);
    localparam logic [10:0] YMIN = 11'(Y_MIN);
    localparam logic [10:0] YMAX = 11'(Y_MAX);
    logic [1:0] s1, s2, deb;
    logic [CW-1:0] cnt [2];
    dir_t state, state_n, cmd, joy;
    logic btn_up, btn_dn, fast;
    logic [10:0] base, step, y_ext, y_up, y_dn, y_cmd;
    logic [9:0] y_n;
    // bit 0 = up button, bit 1 = down button: synchronize then debounce
    always_ff @(posedge clk_d) begin
        if (reset) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            cnt <= '{default: '0};
        end else begin
            s1 <= {move_down, move_up};
            s2 <= s1;
            for (int i = 0; i < 2; i++)
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_END) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end
    end
    // direction command, step size and saturated next position
    always_comb begin
        btn_up  = deb[0] & ~deb[1];
        btn_dn  = deb[1] & ~deb[0];
        joy     = vry <= 4'd5 ? UP : vry >= 4'd10 ? DOWN : HOLD;
        cmd     = btn_up ? UP : btn_dn ? DOWN : joy;
        base    = high_s ? 11'd4 : medium_s ? 11'd2 : 11'd1;
        fast    = !(btn_up | btn_dn) && (vry <= 4'd2 || vry >= 4'd13);
        step    = fast ? base << 1 : base;
        y_ext   = {1'b0, plane_y};
        y_up    = y_ext >= YMIN + step ? y_ext - step : YMIN;
        y_dn    = y_ext + step <= YMAX ? y_ext + step : YMAX;
        y_cmd   = cmd == UP ? y_up : cmd == DOWN ? y_dn : y_ext;
        state_n = frame_tick ? cmd : state;
        y_n     = frame_tick ? y_cmd[9:0] : plane_y;
    end
    // frame pulse plus direction/position registers
    always_ff @(posedge clk_d) begin
        if (reset) begin
            state      <= HOLD;
            plane_y    <= 10'(Y_INIT);
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            plane_y    <= y_n;
            frame_tick <= h_count == 10'd0 && v_count == 10'd480;
        end
    end
    assign dir = state;
endmodule

// File: tb/tb_plane_pos_ctrl.sv
// tb_plane_pos_ctrl: directed checks of debounce, joystick/button steering, saturation and reset
module tb_plane_pos_ctrl;
    logic clk_d = 1'b0, reset = 1'b1, move_up = 1'b0, move_down = 1'b0;
    logic [3:0] vry = 4'd8;
    logic high_s = 1'b0, medium_s = 1'b0, low_s = 1'b0;
    logic [9:0] h_count = 10'd1, v_count = 10'd0;
    logic [9:0] plane_y;
    logic [1:0] dir;
    logic frame_tick;
    int checks = 0, errors = 0, ticks = 0;

    plane_pos_ctrl #(.DEB_CYCLES(4)) dut (
        .clk_d(clk_d), .reset(reset), .move_up(move_up), .move_down(move_down),
        .vry(vry), .high_s(high_s), .medium_s(medium_s), .low_s(low_s),
        .h_count(h_count), .v_count(v_count),
        .plane_y(plane_y), .dir(dir), .frame_tick(frame_tick)
    );

    always #5 clk_d = ~clk_d;
    always @(negedge clk_d) if (frame_tick) ticks++;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_d);
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            @(negedge clk_d);
            h_count = 10'd0;
            v_count = 10'd480;
            @(negedge clk_d);
            h_count = 10'd1;
            v_count = 10'd0;
            @(negedge clk_d);
        end
    endtask

    task automatic pos(input string tag, input int y, input int d);
        chk({tag, "_y"}, int'(plane_y), y);
        chk({tag, "_dir"}, int'(dir), d);
    endtask

    initial begin
        wait_cycles(3);
        reset = 1'b0;
        chk("rst_y", int'(plane_y), 224);
        chk("rst_dir", int'(dir), 0);
        chk("rst_tick", int'(frame_tick), 0);
        frame(3);
        pos("idle", 224, 0);
        chk("tick_count", ticks, 3);
        move_up = 1'b1;
        wait_cycles(2);
        move_up = 1'b0;
        wait_cycles(8);
        frame(1);
        pos("glitch", 224, 0);
        high_s = 1'b1;
        move_up = 1'b1;
        wait_cycles(10);
        frame(1);
        pos("btn_up1", 220, 1);
        frame(1);
        pos("btn_up2", 216, 1);
        move_up = 1'b0;
        wait_cycles(10);
        high_s = 1'b0;
        low_s = 1'b1;
        vry = 4'd5;
        frame(1);
        pos("joy_slow", 215, 1);
        low_s = 1'b0;
        high_s = 1'b1;
        vry = 4'd0;
        frame(26);
        pos("joy_fast_up", 7, 1);
        high_s = 1'b0;
        low_s = 1'b1;
        frame(3);
        pos("near_min", 1, 1);
        frame(1);
        pos("sat_min", 0, 1);
        frame(1);
        pos("hold_min", 0, 1);
        low_s = 1'b0;
        high_s = 1'b1;
        vry = 4'd15;
        frame(55);
        pos("joy_fast_dn", 440, 2);
        move_down = 1'b1;
        vry = 4'd0;
        wait_cycles(10);
        frame(1);
        pos("btn_dn_nodbl", 444, 2);
        move_down = 1'b0;
        wait_cycles(10);
        high_s = 1'b0;
        low_s = 1'b1;
        vry = 4'd10;
        frame(2);
        pos("joy_edge_dn", 446, 2);
        low_s = 1'b0;
        medium_s = 1'b1;
        vry = 4'd15;
        frame(1);
        pos("sat_max", 448, 2);
        frame(1);
        pos("hold_max", 448, 2);
        medium_s = 1'b0;
        low_s = 1'b1;
        vry = 4'd5;
        frame(1);
        pos("from_max", 447, 1);
        move_up = 1'b1;
        move_down = 1'b1;
        vry = 4'd11;
        wait_cycles(10);
        frame(1);
        pos("both_btn", 448, 2);
        vry = 4'd8;
        frame(1);
        pos("both_dead", 448, 0);
        move_up = 1'b0;
        move_down = 1'b0;
        wait_cycles(10);
        low_s = 1'b0;
        high_s = 1'b1;
        vry = 4'd0;
        frame(1);
        pos("pre_rst", 440, 1);
        @(negedge clk_d);
        h_count = 10'd0;
        v_count = 10'd480;
        @(negedge clk_d);
        h_count = 10'd1;
        v_count = 10'd0;
        chk("tick_before_rst", int'(frame_tick), 1);
        reset = 1'b1;
        @(negedge clk_d);
        reset = 1'b0;
        pos("rst_on_tick", 224, 0);
        chk("rst_on_tick_pulse", int'(frame_tick), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
